// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the codec I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, NEXT, DONE} state_t;

  typedef logic [15:0] lutWord_t;

  // Frame layout: START, 3 x (8 data + ACK slot), STOP
  localparam int BYTES_PER_FRAME = 3;
  localparam int SLOTS_PER_BYTE  = 9;
  localparam int FRAME_BITS      = 2 + BYTES_PER_FRAME * SLOTS_PER_BYTE;
  localparam int STOP_BIT        = FRAME_BITS - 1;

  // iCLK cycles per quarter SCL bit, never below 1
  function automatic int tickDiv(input int clkFreq, input int i2cFreq);
    int d;
    d = clkFreq / (4 * i2cFreq);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/i2c_codec_config_seq_if.sv
// Control/status bundle between the sequencer and its host.
interface i2c_codec_config_seq_if;
  logic       iSTART;
  logic [6:0] iVOL;
  logic       iMUTE;
  logic       o_I2C_END;
  logic       o_I2C_ERR;
  logic       o_BUSY;
  logic [3:0] o_INDEX;

  modport master (output iSTART, iVOL, iMUTE,
                  input  o_I2C_END, o_I2C_ERR, o_BUSY, o_INDEX);
  modport slave  (input  iSTART, iVOL, iMUTE,
                  output o_I2C_END, o_I2C_ERR, o_BUSY, o_INDEX);
endinterface

// File: rtl/i2c_write3_engine.sv
// Bit-level I2C engine: sends one START, 3 bytes with ACK slots, STOP.
// Each bit is 4 ticks; SCL high on quarters 2-3. Data is placed on
// quarter 1 so SDA only moves while SCL is low.
module i2c_write3_engine
  import i2c_cfg_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        tick,
  input  logic        go,
  input  logic [23:0] data,
  input  logic        sdaIn,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        sclk,
  output logic        sdaOe
);

  localparam logic [4:0] STOP_B = 5'(STOP_BIT);

  logic [4:0]  bitCnt, nBit;
  logic [3:0]  slot, nSlot;
  logic [1:0]  q, nQ;
  logic [23:0] shiftR;
  logic        finish, ackSlot, ackNack;

  // Next bit position; an ACK slot that reads high jumps straight to STOP
  always_comb begin
    nBit    = bitCnt;
    nSlot   = slot;
    nQ      = q + 2'd1;
    finish  = 1'b0;
    ackSlot = (bitCnt != 5'd0) && (bitCnt != STOP_B) && (slot == 4'd8);
    ackNack = ackSlot && sdaIn;
    if (q == 2'd3) begin
      if (bitCnt == STOP_B) finish = 1'b1;
      else if (bitCnt == 5'd0) begin
        nBit  = 5'd1;
        nSlot = 4'd0;
      end else if (slot == 4'd8) begin
        nSlot = 4'd0;
        nBit  = ackNack ? STOP_B : bitCnt + 5'd1;
      end else begin
        nSlot = slot + 4'd1;
        nBit  = bitCnt + 5'd1;
      end
    end
  end

  // Position counters, shifter and registered bus drive
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      nack   <= 1'b0;
      sclk   <= 1'b1;
      sdaOe  <= 1'b0;
      bitCnt <= '0;
      slot   <= '0;
      q      <= '0;
      shiftR <= '0;
    end else begin
      done <= 1'b0;
      if (go && !busy) begin
        busy   <= 1'b1;
        nack   <= 1'b0;
        bitCnt <= '0;
        slot   <= '0;
        q      <= '0;
        shiftR <= data;
        sclk   <= 1'b1;
        sdaOe  <= 1'b0;
      end else if (busy && tick) begin
        if (finish) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          sclk  <= 1'b1;
          sdaOe <= 1'b0;
        end else begin
          bitCnt <= nBit;
          slot   <= nSlot;
          q      <= nQ;
          if (q == 2'd3 && ackNack) nack <= 1'b1;
          if (q == 2'd3 && bitCnt != 5'd0 && bitCnt != STOP_B && slot != 4'd8)
            shiftR <= {shiftR[22:0], 1'b0};
          sclk <= (nBit == 5'd0) ? 1'b1 : nQ[1];
          if (nBit == 5'd0) sdaOe <= nQ[1];
          else if (nBit == STOP_B) begin
            if (nQ == 2'd1) sdaOe <= 1'b1;
            else if (nQ == 2'd3) sdaOe <= 1'b0;
          end else if (nQ == 2'd1) sdaOe <= (nSlot == 4'd8) ? 1'b0 : ~shiftR[23];
        end
      end
    end
  end

endmodule

// File: rtl/i2c_codec_config_seq.sv
// Codec setup sequencer: walks the init LUT over I2C, retries NACKs,
// and rewrites only the headphone volume words when iVOL/iMUTE change.
module i2c_codec_config_seq
  import i2c_cfg_pkg::*;
#(
  parameter int                    CLK_FREQ   = 50_000_000,
  parameter int                    I2C_FREQ   = 100_000,
  parameter logic [7:0]            SLAVE_ADDR = 8'h34,
  parameter int                    LUT_SIZE   = 12,
  parameter logic [LUT_SIZE*16-1:0] INIT_TABLE = {LUT_SIZE{16'h0}},
  parameter int                    VOL_L_IDX  = 4,
  parameter int                    VOL_R_IDX  = 5,
  parameter int                    MAX_RETRY  = 3
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  i2c_codec_config_seq_if.slave   cfg,
  output logic                    I2C_SCLK,
  inout  wire                     I2C_SDAT
);

  localparam int         TICK_DIV = tickDiv(CLK_FREQ, I2C_FREQ);
  localparam logic [3:0] LAST_IDX = 4'(LUT_SIZE - 1);
  localparam logic [3:0] L_IDX    = 4'(VOL_L_IDX);
  localparam logic [3:0] R_IDX    = 4'(VOL_R_IDX);

  state_t     state, stateN;
  logic [3:0] idx, idxN, retry, retryN;
  logic       fullMode, fullN, updSecond, updSecondN;
  logic       startPend, startPendN, endR, endN, errR, errN;
  logic [7:0] volSent, volSentN;
  logic [15:0] tickCnt;
  logic       tick, go, updPend, isVolIdx;
  logic       engBusy, engDone, engNack, sdaOe;
  logic [7:0] volIn;
  logic [6:0] volField;
  lutWord_t   lutRaw, word;

  function automatic lutWord_t lutAt(input logic [3:0] i);
    lutAt = (32'(i) < LUT_SIZE) ? INIT_TABLE[16*i +: 16] : '0;
  endfunction

  assign tick     = (tickCnt == 16'(TICK_DIV - 1));
  assign volIn    = {cfg.iMUTE, cfg.iVOL};
  assign volField = cfg.iMUTE ? 7'h00 : cfg.iVOL;
  assign lutRaw   = lutAt(idx);
  assign isVolIdx = (idx == L_IDX) || (idx == R_IDX);
  assign word     = isVolIdx ? {lutRaw[15:7], volField} : lutRaw;
  assign go       = (state == LOAD);
  assign updPend  = endR && (volIn != volSent);

  // Quarter-bit tick divider
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) tickCnt <= '0;
    else         tickCnt <= tick ? '0 : tickCnt + 16'd1;
  end

  // Sequencer next state; a pending start always beats a pending update
  always_comb begin
    stateN     = state;
    idxN       = idx;
    retryN     = retry;
    fullN      = fullMode;
    updSecondN = updSecond;
    startPendN = startPend | cfg.iSTART;
    endN       = endR;
    errN       = errR;
    volSentN   = volSent;
    case (state)
      IDLE: begin
        if (startPend) begin
          stateN     = LOAD;
          idxN       = '0;
          fullN      = 1'b1;
          startPendN = cfg.iSTART;
          errN       = 1'b0;
          endN       = 1'b0;
          retryN     = '0;
        end else if (updPend) begin
          stateN     = LOAD;
          idxN       = L_IDX;
          fullN      = 1'b0;
          updSecondN = 1'b0;
          endN       = 1'b0;
          retryN     = '0;
        end
      end
      LOAD: begin
        stateN = WAIT;
        if (isVolIdx) volSentN = volIn;
      end
      WAIT: begin
        if (engDone) begin
          if (!engNack) stateN = NEXT;
          else if (retry < 4'(MAX_RETRY)) begin
            retryN = retry + 4'd1;
            stateN = LOAD;
          end else begin
            errN   = 1'b1;
            stateN = NEXT;
          end
        end
      end
      NEXT: begin
        retryN = '0;
        if (startPend) begin
          stateN     = LOAD;
          idxN       = '0;
          fullN      = 1'b1;
          startPendN = cfg.iSTART;
          errN       = 1'b0;
        end else if (fullMode) begin
          if (idx == LAST_IDX) begin
            stateN = DONE;
            endN   = 1'b1;
          end else begin
            idxN   = idx + 4'd1;
            stateN = LOAD;
          end
        end else if (!updSecond) begin
          idxN       = R_IDX;
          updSecondN = 1'b1;
          stateN     = LOAD;
        end else begin
          stateN = DONE;
          endN   = 1'b1;
        end
      end
      DONE:    stateN = IDLE;
      default: stateN = IDLE;
    endcase
  end

  // Sequencer registers; start is pending out of reset
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      idx       <= '0;
      retry     <= '0;
      fullMode  <= 1'b1;
      updSecond <= 1'b0;
      startPend <= 1'b1;
      endR      <= 1'b0;
      errR      <= 1'b0;
      volSent   <= '0;
    end else begin
      state     <= stateN;
      idx       <= idxN;
      retry     <= retryN;
      fullMode  <= fullN;
      updSecond <= updSecondN;
      startPend <= startPendN;
      endR      <= endN;
      errR      <= errN;
      volSent   <= volSentN;
    end
  end

  i2c_write3_engine u_eng (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .tick   (tick),
    .go     (go),
    .data   ({SLAVE_ADDR, word}),
    .sdaIn  (I2C_SDAT),
    .busy   (engBusy),
    .done   (engDone),
    .nack   (engNack),
    .sclk   (I2C_SCLK),
    .sdaOe  (sdaOe)
  );

  assign I2C_SDAT      = sdaOe ? 1'b0 : 1'bz;
  assign cfg.o_I2C_END = endR;
  assign cfg.o_I2C_ERR = errR;
  assign cfg.o_BUSY    = (state == LOAD) || (state == WAIT) || (state == NEXT) || engBusy;
  assign cfg.o_INDEX   = idx;

endmodule

// File: tb/tb_i2c_codec_config_seq.sv
// Directed bench: I2C slave model at 8'h34 with programmable NACKs.
`timescale 1ns/1ps
module tb_i2c_codec_config_seq;

  localparam logic [63:0] TABLE = 64'h4051_2E3D_1C2B_0A17;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  i2c_codec_config_seq_if cfg();
  wire  sclk;
  wire  sdat;
  logic bfmOe = 1'b0;
  pullup (sdat);
  assign sdat = bfmOe ? 1'b0 : 1'bz;

  i2c_codec_config_seq #(
    .CLK_FREQ(800_000), .I2C_FREQ(100_000), .SLAVE_ADDR(8'h34), .LUT_SIZE(4),
    .INIT_TABLE(TABLE), .VOL_L_IDX(1), .VOL_R_IDX(2), .MAX_RETRY(3)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .cfg(cfg), .I2C_SCLK(sclk), .I2C_SDAT(sdat)
  );

  // Slave model: records {byte count, 3 bytes} per frame at STOP
  logic [31:0] frames[$];
  logic        prevS = 1'b1, prevD = 1'b1, inFrame = 1'b0, ackPend = 1'b0, ackHeld = 1'b0;
  int          bitCnt = 0, byteCnt = 0, nackHits = 0, nackLimit = 0;
  logic [7:0]  sh = '0, nackReg = 8'hFF;
  logic [23:0] fw = '0;
  wire  [7:0]  bNow = {sh[6:0], sdat};

  always @(negedge iCLK) begin
    if (!iRST_N) begin
      inFrame <= 1'b0; ackPend <= 1'b0; ackHeld <= 1'b0; bfmOe <= 1'b0;
      prevS <= 1'b1; prevD <= 1'b1;
    end else begin
      prevS <= sclk;
      prevD <= sdat;
      if (prevS && sclk && prevD && !sdat) begin
        inFrame <= 1'b1; bitCnt <= 0; byteCnt <= 0; fw <= '0;
      end else if (prevS && sclk && !prevD && sdat) begin
        if (inFrame) frames.push_back({byteCnt[7:0], fw});
        inFrame <= 1'b0;
      end else if (!prevS && sclk && inFrame) begin
        if (bitCnt < 8) begin
          sh     <= bNow;
          bitCnt <= bitCnt + 1;
          if (bitCnt == 7) begin
            fw      <= {fw[15:0], bNow};
            byteCnt <= byteCnt + 1;
            if (byteCnt == 0) ackPend <= (bNow == 8'h34);
            else if (byteCnt == 2 && fw[7:0] == nackReg && nackHits < nackLimit) begin
              ackPend  <= 1'b0;
              nackHits <= nackHits + 1;
            end else ackPend <= 1'b1;
          end
        end else bitCnt <= 0;
      end else if (prevS && !sclk) begin
        if (ackPend) begin
          bfmOe <= 1'b1; ackPend <= 1'b0; ackHeld <= 1'b1;
        end else if (ackHeld) begin
          bfmOe <= 1'b0; ackHeld <= 1'b0;
        end
      end
    end
  end

  int nChecks = 0, nErrors = 0;
  int base = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkFrame(input string tag, input int k, input logic [31:0] exp);
    chk(tag, (frames.size() > base + k) ? frames[base + k] : 32'hFFFF_FFFF, exp);
  endtask

  task automatic pulseStart();
    @(negedge iCLK) cfg.iSTART = 1'b1;
    @(negedge iCLK) cfg.iSTART = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge iCLK);
    while (!(cfg.o_I2C_END && !cfg.o_BUSY) && n < 6000) begin
      @(negedge iCLK);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 6000), 32'd1);
  endtask

  initial begin
    int n;
    cfg.iSTART = 1'b0; cfg.iVOL = 7'h79; cfg.iMUTE = 1'b0;
    repeat (5) @(negedge iCLK);
    chk("rst_end",   32'(cfg.o_I2C_END), 32'd0);
    chk("rst_err",   32'(cfg.o_I2C_ERR), 32'd0);
    chk("rst_busy",  32'(cfg.o_BUSY),    32'd0);
    chk("rst_index", 32'(cfg.o_INDEX),   32'd0);
    chk("rst_sclk",  32'(sclk),          32'd1);
    chk("rst_sdat",  32'(sdat),          32'd1);

    // 1: automatic pass after reset, all ACK
    base = frames.size();
    iRST_N = 1'b1;
    waitDone("t1");
    chk("t1_cnt", 32'(frames.size() - base), 32'd4);
    chkFrame("t1_f0", 0, 32'h0334_0A17);
    chkFrame("t1_f1", 1, 32'h0334_1C79);
    chkFrame("t1_f2", 2, 32'h0334_2E79);
    chkFrame("t1_f3", 3, 32'h0334_4051);
    chk("t1_end", 32'(cfg.o_I2C_END), 32'd1);
    chk("t1_err", 32'(cfg.o_I2C_ERR), 32'd0);

    // 2: word 2 NACKed twice, third attempt succeeds
    nackReg = 8'h2E; nackLimit = nackHits + 2;
    base = frames.size();
    pulseStart();
    waitDone("t2");
    chk("t2_cnt", 32'(frames.size() - base), 32'd6);
    chkFrame("t2_f2", 2, 32'h0334_2E79);
    chkFrame("t2_f4", 4, 32'h0334_2E79);
    chkFrame("t2_f5", 5, 32'h0334_4051);
    chk("t2_err", 32'(cfg.o_I2C_ERR), 32'd0);

    // 3: word 1 always NACKed -> 4 attempts, error, pass continues
    nackReg = 8'h1C; nackLimit = nackHits + 1000;
    base = frames.size();
    pulseStart();
    waitDone("t3");
    chk("t3_cnt", 32'(frames.size() - base), 32'd7);
    chkFrame("t3_f1", 1, 32'h0334_1C79);
    chkFrame("t3_f4", 4, 32'h0334_1C79);
    chkFrame("t3_f5", 5, 32'h0334_2E79);
    chkFrame("t3_f6", 6, 32'h0334_4051);
    chk("t3_err", 32'(cfg.o_I2C_ERR), 32'd1);
    chk("t3_end", 32'(cfg.o_I2C_END), 32'd1);
    nackLimit = nackHits;

    // 4: volume change -> only the L/R words
    base = frames.size();
    cfg.iVOL = 7'h50;
    waitDone("t4");
    repeat (400) @(negedge iCLK);
    chk("t4_cnt", 32'(frames.size() - base), 32'd2);
    chkFrame("t4_l", 0, 32'h0334_1C50);
    chkFrame("t4_r", 1, 32'h0334_2E50);
    chk("t4_err_sticky", 32'(cfg.o_I2C_ERR), 32'd1);

    // 5a: mute forces volume field to zero
    base = frames.size();
    cfg.iMUTE = 1'b1;
    waitDone("t5a");
    repeat (400) @(negedge iCLK);
    chk("t5a_cnt", 32'(frames.size() - base), 32'd2);
    chkFrame("t5a_l", 0, 32'h0334_1C00);
    chkFrame("t5a_r", 1, 32'h0334_2E00);

    // 5b: iSTART during frame 1 -> frame completes, restart at 0
    base = frames.size();
    pulseStart();
    n = 0;
    while (!(frames.size() >= base + 1 && inFrame) && n < 6000) begin
      @(negedge iCLK);
      n++;
    end
    chk("t5b_sync", 32'(n < 6000), 32'd1);
    chk("t5b_index", 32'(cfg.o_INDEX), 32'd1);
    pulseStart();
    waitDone("t5b");
    chk("t5b_cnt", 32'(frames.size() - base), 32'd6);
    chkFrame("t5b_f1", 1, 32'h0334_1C00);
    chkFrame("t5b_f2", 2, 32'h0334_0A17);
    chkFrame("t5b_f5", 5, 32'h0334_4051);
    chk("t5b_err", 32'(cfg.o_I2C_ERR), 32'd0);

    // 6: reset mid-byte of frame 1, then fresh pass from index 0
    base = frames.size();
    pulseStart();
    n = 0;
    while (!(frames.size() >= base + 1 && inFrame && byteCnt == 1 && bitCnt == 4) && n < 6000) begin
      @(negedge iCLK);
      n++;
    end
    chk("t6_sync", 32'(n < 6000), 32'd1);
    iRST_N = 1'b0;
    #1;
    chk("t6_sclk",  32'(sclk),          32'd1);
    chk("t6_sdat",  32'(sdat),          32'd1);
    chk("t6_busy",  32'(cfg.o_BUSY),    32'd0);
    chk("t6_index", 32'(cfg.o_INDEX),   32'd0);
    chk("t6_end",   32'(cfg.o_I2C_END), 32'd0);
    chk("t6_err",   32'(cfg.o_I2C_ERR), 32'd0);
    repeat (3) @(negedge iCLK);
    base = frames.size();
    iRST_N = 1'b1;
    waitDone("t6");
    chk("t6_cnt", 32'(frames.size() - base), 32'd4);
    chkFrame("t6_f0", 0, 32'h0334_0A17);
    chkFrame("t6_f3", 3, 32'h0334_4051);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
